hub75_bcm_scan_ctrl: RTL and testbench

- Next-generation HUB75 LED-matrix scan controller. Replaces the external-counter control FSM with a self-contained, parametrised sequencer.
- Owns its column, row, bit-plane and delay counters. Adds binary-coded-modulation (BCM) plane weighting, global brightness dimming, continuous refresh, and a double-buffer swap handshake.
- Sits between the frame-buffer RAM (1-cycle read latency) and the panel pins.

---
 rtl/hub75_bcm_scan_ctrl_if.sv | 39 +++
 rtl/hub75_bcm_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_hub75_bcm_scan_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_bcm_scan_ctrl_if.sv
// HUB75 scan controller bus: host controls in, panel/frame-buffer strobes out.
// master = controller side, slave = host/panel side.
interface hub75_bcm_scan_ctrl_if #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int BPP      = 8
);
  localparam int CW = $clog2(COLS);
  localparam int PW = (BPP > 1) ? $clog2(BPP) : 1;

  logic                init;
  logic                loop;
  logic [7:0]          brightness;
  logic                swap_req;
  logic [CW-1:0]       col_addr;
  logic [ROW_BITS-1:0] row_rd;
  logic [PW-1:0]       plane;
  logic                buf_sel;
  logic                px_clk_en;
  logic                latch;
  logic                noe;
  logic [ROW_BITS-1:0] row_addr;
  logic                busy;
  logic                frame_done;

  modport master (
    input  init, loop, brightness, swap_req,
    output col_addr, row_rd, plane, buf_sel,
    output px_clk_en, latch, noe, row_addr,
    output busy, frame_done
  );

  modport slave (
    output init, loop, brightness, swap_req,
    input  col_addr, row_rd, plane, buf_sel,
    input  px_clk_en, latch, noe, row_addr,
    input  busy, frame_done
  );
endinterface

// File: rtl/hub75_bcm_scan_ctrl.sv
// HUB75 BCM scan sequencer: clk, rst, bus (init/loop/brightness/swap_req in;
// col/row/plane/buf_sel addresses, px_clk_en/latch/noe/row_addr, busy/frame_done out).
module hub75_bcm_scan_ctrl #(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 5,
  parameter int BPP        = 8,
  parameter int BASE_DELAY = 16,
  parameter int BLANK_CYC  = 2
) (
  input logic clk,
  input logic rst,
  hub75_bcm_scan_ctrl_if.master bus
);
  localparam int CW   = $clog2(COLS);
  localparam int PW   = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int WMAX = BASE_DELAY << (BPP - 1);
  localparam int DW   = $clog2(WMAX) + 1;
  localparam int BW   = $clog2(BLANK_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, SHIFT, BLANK,
    LATCH, DISP, NEXT, FEND
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PW-1:0]       plane_q, plane_d;
  logic [DW-1:0]       dly_q, dly_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [DW-1:0]       thr_q, thr_d;
  logic                buf_q, buf_d;
  logic                pend_q, pend_d;
  logic [ROW_BITS-1:0] rowo_q, rowo_d;

  logic [DW-1:0]   win;
  logic [DW+7:0]   prod;
  logic            col_last;
  logic            plane_last;
  logic            row_last;
  logic            blank_last;
  logic            disp_last;

  assign win        = DW'(BASE_DELAY) << plane_q;
  assign prod       = (DW+8)'(win) * (DW+8)'(bus.brightness);
  assign col_last   = (col_q == CW'(COLS - 1));
  assign plane_last = (plane_q == PW'(BPP - 1));
  assign row_last   = &row_q;
  assign blank_last = (bcnt_q == BW'(BLANK_CYC - 1));
  assign disp_last  = (dly_q == win - DW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      plane_q <= '0;
      dly_q   <= '0;
      bcnt_q  <= '0;
      thr_q   <= '0;
      buf_q   <= 1'b0;
      pend_q  <= 1'b0;
      rowo_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      dly_q   <= dly_d;
      bcnt_q  <= bcnt_d;
      thr_q   <= thr_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      rowo_q  <= rowo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.init) state_d = FETCH;
      FETCH: state_d = SHIFT;
      SHIFT: state_d = col_last ? BLANK : FETCH;
      BLANK: if (blank_last) state_d = LATCH;
      LATCH: state_d = DISP;
      DISP:  if (disp_last) state_d = NEXT;
      NEXT:  state_d = (plane_last && row_last)
                       ? FEND : FETCH;
      FEND:  state_d = bus.loop ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    plane_d = plane_q;
    dly_d   = dly_q;
    bcnt_d  = bcnt_q;
    thr_d   = thr_q;
    buf_d   = buf_q;
    pend_d  = pend_q | bus.swap_req;
    rowo_d  = rowo_q;
    unique case (state_q)
      SHIFT: col_d = col_last ? '0 : col_q + CW'(1);
      BLANK: begin
        if (bcnt_q == '0) rowo_d = row_q;
        bcnt_d = blank_last ? '0 : bcnt_q + BW'(1);
      end
      LATCH: begin
        dly_d = '0;
        thr_d = (bus.brightness == 8'hFF)
                ? win : prod[DW+7:8];
      end
      DISP: dly_d = dly_q + DW'(1);
      NEXT: begin
        dly_d = '0;
        if (plane_last) begin
          plane_d = '0;
          row_d   = row_q + ROW_BITS'(1);
        end else begin
          plane_d = plane_q + PW'(1);
        end
      end
      FEND: begin
        // a request landing in this cycle waits for the next frame end
        if (pend_q) buf_d = ~buf_q;
        pend_d = bus.swap_req;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.col_addr   = col_q;
    bus.row_rd     = row_q;
    bus.plane      = plane_q;
    bus.buf_sel    = buf_q;
    bus.row_addr   = rowo_q;
    bus.px_clk_en  = (state_q == SHIFT);
    bus.latch      = (state_q == LATCH);
    bus.frame_done = (state_q == FEND);
    bus.busy       = (state_q != IDLE);
    bus.noe        = !((state_q == DISP) &&
                       (dly_q < thr_q));
  end
endmodule

// File: tb/tb_hub75_bcm_scan_ctrl.sv
// Directed vector bench for hub75_bcm_scan_ctrl.
// Small geometry: 4 cols, 2 rows, 2 planes, base window 4, 2 blank clocks.
module tb_hub75_bcm_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hub75_bcm_scan_ctrl_if #(
    .COLS(4), .ROW_BITS(1), .BPP(2)
  ) bus ();

  hub75_bcm_scan_ctrl #(
    .COLS(4), .ROW_BITS(1), .BPP(2),
    .BASE_DELAY(4), .BLANK_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] br;
    int         chg_cyc;
    logic [7:0] chg_val;
    int         w[4];
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  int fd_cyc, px, lat, nwin, run, rowviol;
  int busy_end, c0_col, c0_row, c0_pl;
  int wins[8];
  logic prev_row;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " noe"}, int'(bus.noe), 1);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " latch"}, int'(bus.latch), 0);
    chk({tag, " px"}, int'(bus.px_clk_en), 0);
    chk({tag, " fd"}, int'(bus.frame_done), 0);
    chk({tag, " col"}, int'(bus.col_addr), 0);
    chk({tag, " row_rd"}, int'(bus.row_rd), 0);
    chk({tag, " plane"}, int'(bus.plane), 0);
    chk({tag, " row_addr"}, int'(bus.row_addr), 0);
    chk({tag, " buf"}, int'(bus.buf_sel), 0);
  endtask

  // Starts from IDLE just after a negedge; returns after
  // sampling the cycle after frame_done.
  task automatic run_frame(input int chg_cyc,
                           input logic [7:0] chg_val);
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    fd_cyc = -1; px = 0; lat = 0;
    nwin = 0; run = 0; rowviol = 0;
    busy_end = 1;
    for (int k = 0; k < 8; k++) wins[k] = 0;
    prev_row = bus.row_addr;
    c0_col = int'(bus.col_addr);
    c0_row = int'(bus.row_rd);
    c0_pl  = int'(bus.plane);
    for (int c = 0; c < 200; c++) begin
      if (c == chg_cyc) bus.brightness = chg_val;
      if (bus.px_clk_en) px++;
      if (bus.latch) lat++;
      if (!bus.noe) run++;
      else if (run > 0) begin
        if (nwin < 8) wins[nwin] = run;
        nwin++;
        run = 0;
      end
      if (bus.row_addr != prev_row && !bus.noe)
        rowviol++;
      prev_row = bus.row_addr;
      if (bus.frame_done) begin
        fd_cyc = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    busy_end = int'(bus.busy);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("wait idle", int'(bus.busy), 0);
  endtask

  vec_t tv[7];
  int fds[4];
  int togs[4];
  int nfd, ntog, idle_at, fdn;
  logic pbuf;

  initial begin
    int e[4];
    int ne;
    tv[0] = '{8'd255, -1, 8'd0,   '{4, 8, 4, 8}};
    tv[1] = '{8'd128, -1, 8'd0,   '{2, 4, 2, 4}};
    tv[2] = '{8'd0,   -1, 8'd0,   '{0, 0, 0, 0}};
    tv[3] = '{8'd200, -1, 8'd0,   '{3, 6, 3, 6}};
    tv[4] = '{8'd64,  -1, 8'd0,   '{1, 2, 1, 2}};
    tv[5] = '{8'd255, 12, 8'd0,   '{4, 0, 0, 0}};
    tv[6] = '{8'd0,   28, 8'd255, '{0, 0, 4, 8}};

    bus.init = 1'b0;
    bus.loop = 1'b0;
    bus.brightness = 8'd255;
    bus.swap_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (tv[i]) begin
      bus.brightness = tv[i].br;
      run_frame(tv[i].chg_cyc, tv[i].chg_val);
      chk($sformatf("v%0d frame_end cyc", i), fd_cyc, 72);
      chk($sformatf("v%0d px pulses", i), px, 16);
      chk($sformatf("v%0d latches", i), lat, 4);
      chk($sformatf("v%0d busy after", i), busy_end, 0);
      chk($sformatf("v%0d row_addr in display", i),
          rowviol, 0);
      chk($sformatf("v%0d row_addr end", i),
          int'(bus.row_addr), 1);
      ne = 0;
      for (int k = 0; k < 4; k++)
        if (tv[i].w[k] != 0) begin
          e[ne] = tv[i].w[k];
          ne++;
        end
      chk($sformatf("v%0d noe windows", i), nwin, ne);
      for (int k = 0; k < ne; k++)
        chk($sformatf("v%0d window %0d", i, k),
            wins[k], e[k]);
    end

    // continuous refresh with swap requests
    bus.brightness = 8'd255;
    bus.loop = 1'b1;
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    nfd = 0; ntog = 0; idle_at = -1;
    pbuf = bus.buf_sel;
    for (int c = 0; c < 400; c++) begin
      if (!bus.busy) begin
        idle_at = c;
        break;
      end
      if (bus.buf_sel != pbuf) begin
        if (ntog < 4) togs[ntog] = c;
        ntog++;
      end
      pbuf = bus.buf_sel;
      if (bus.frame_done) begin
        if (nfd < 4) fds[nfd] = c;
        nfd++;
      end
      bus.swap_req = (c == 5) || (c == 30) ||
                     (bus.frame_done && nfd == 2);
      if (c == 219) bus.loop = 1'b0;
      @(negedge clk);
    end
    bus.swap_req = 1'b0;
    chk("loop frames", nfd, 4);
    chk("loop fd0", fds[0], 72);
    chk("loop fd1", fds[1], 145);
    chk("loop fd2", fds[2], 218);
    chk("loop fd3", fds[3], 291);
    chk("swap toggles", ntog, 2);
    chk("swap tog0", togs[0], 73);
    chk("swap tog1", togs[1], 219);
    chk("loop idle at", idle_at, 292);

    // init held high: no mid-frame retrigger
    bus.init = 1'b1;
    @(negedge clk);
    fdn = 0;
    for (int c = 0; c < 75; c++) begin
      if (bus.frame_done) fdn++;
      if (c == 73)
        chk("hold idle gap", int'(bus.busy), 0);
      if (c == 74)
        chk("hold restart", int'(bus.busy), 1);
      @(negedge clk);
    end
    chk("hold frame_done count", fdn, 1);
    bus.init = 1'b0;
    wait_idle();

    // async reset in row 1 plane 1 display
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    repeat (65) @(negedge clk);
    chk("pre-rst noe", int'(bus.noe), 0);
    chk("pre-rst plane", int'(bus.plane), 1);
    chk("pre-rst row", int'(bus.row_rd), 1);
    #2 rst = 1'b1;
    #1 chk_rst("async rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(-1, 8'd0);
    chk("post-rst col0", c0_col, 0);
    chk("post-rst row0", c0_row, 0);
    chk("post-rst plane0", c0_pl, 0);
    chk("post-rst frame", fd_cyc, 72);
    chk("post-rst windows", nwin, 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
